// File: rtl/alu_pkg.sv
// Opcode constants, FSM state encoding and the single-cycle ALU evaluation
// shared by the arbiter and its datapath.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLTS = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_LTS  = 5'b11100;
  localparam logic [4:0] OP_GES  = 5'b11101;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GEU  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        flag;
  } alu_out_t;

  // Compares drive only the flag; undefined opcodes fall through to all-zero.
  function automatic alu_out_t alu_eval(input logic [4:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    alu_out_t   o;
    logic [4:0] sh;
    o  = '0;
    sh = b[4:0];
    case (op)
      OP_ADD:  o.result = a + b;
      OP_SUB:  o.result = a - b;
      OP_SLL:  o.result = a << sh;
      OP_SLTS: o.result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: o.result = {31'd0, a < b};
      OP_XOR:  o.result = a ^ b;
      OP_SRL:  o.result = a >> sh;
      OP_SRA:  o.result = $signed(a) >>> sh;
      OP_OR:   o.result = a | b;
      OP_AND:  o.result = a & b;
      OP_EQ:   o.flag   = (a == b);
      OP_NE:   o.flag   = (a != b);
      OP_LTS:  o.flag   = $signed(a) < $signed(b);
      OP_GES:  o.flag   = $signed(a) >= $signed(b);
      OP_LTU:  o.flag   = a < b;
      OP_GEU:  o.flag   = a >= b;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) grant = last ? 2'b01 : 2'b10;
    else if (valid0)      grant = 2'b01;
    else if (valid1)      grant = 2'b10;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters sharing one ALU through an IDLE/EXEC/RESP handshake FSM.
// Per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_flag
);

  // state | meaning
  // IDLE  | no operation in flight; grant one requester combinationally
  // EXEC  | evaluate the latched operation, register result and flag
  // RESP  | present result to owner until it is consumed

  state_t            state_q, state_d;
  logic [1:0]        grant;
  logic              accept;
  logic              rsp_take;
  logic              owner_q;
  logic              last_q;
  logic [4:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  alu_out_t          alu_res;

  rr_arb2 u_rr (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_q),
    .grant  (grant)
  );

  // Gated with rst so no ready leaks out while reset is held.
  assign accept   = (state_q == ST_IDLE) && !rst && (grant != 2'b00);
  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;
  assign alu_res  = alu_eval(op_q, a_q, b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        if (rsp_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant[1];
        last_q  <= grant[1];
        op_q    <= grant[1] ? req1_op : req0_op;
        a_q     <= grant[1] ? req1_a  : req0_a;
        b_q     <= grant[1] ? req1_b  : req0_b;
      end
      if (state_q == ST_EXEC) begin
        rsp_result <= alu_res.result;
        rsp_flag   <= alu_res.flag;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (grant[0] && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant[1] && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
